// File: rtl/dbram_pingpong_pkg.sv
// Shared constants for the ping-pong double-buffer RAM: bank state encodings
// and default geometry.
package dbram_pingpong_pkg;

    localparam logic BANK_FREE = 1'b0;
    localparam logic BANK_FULL = 1'b1;

    localparam int DEF_AWIDTH    = 11;
    localparam int DEF_NUM_WORDS = 2048;
    localparam int DEF_DWIDTH    = 40;
    localparam int DEF_OUT_REG   = 1;

endpackage

// File: rtl/dbram_pingpong_bank.sv
// Simple dual-port RAM bank: one write port, one registered read port.
// The read register only updates on re, so its output holds between reads.
module dpram_bank
    import dbram_pingpong_pkg::*;
#(
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

`ifdef hard_mem
    dual_port_ram #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .re   (re),
        .raddr(raddr),
        .rdata(rdata)
    );
`else
    logic [DWIDTH-1:0] mem [NUM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/dbram_pingpong.sv
// Ping-pong double buffer: a producer fills one bank while a consumer drains
// the other; commit/release hand banks across via FREE/FULL state.
module dbram_pingpong
    import dbram_pingpong_pkg::*;
#(
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int OUT_REG   = DEF_OUT_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              rd_release,
    output logic              rd_ready,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              err_wr,
    output logic              err_rd
);

    logic [1:0] state_reg, state_next;
    logic       wp_reg, wp_next;
    logic       rp_reg, rp_next;
    logic       err_wr_reg, err_wr_next;
    logic       err_rd_reg, err_rd_next;
    logic       s1_valid_reg;
    logic       s1_bank_reg;

    logic wr_fire, commit_fire, rd_fire, release_fire;
    logic [DWIDTH-1:0] bank_rdata [2];

    assign wr_ready     = (state_reg[wp_reg] == BANK_FREE);
    assign rd_ready     = (state_reg[rp_reg] == BANK_FULL);
    assign wr_fire      = wr_en && wr_ready;
    assign commit_fire  = wr_commit && wr_ready;
    assign rd_fire      = rd_en && rd_ready;
    assign release_fire = rd_release && rd_ready;

    assign wr_bank = wp_reg;
    assign rd_bank = rp_reg;
    assign err_wr  = err_wr_reg;
    assign err_rd  = err_rd_reg;

    // Commit and release touch different banks whenever both are legal, so
    // they can be applied independently in the same cycle.
    always_comb begin
        state_next  = state_reg;
        wp_next     = wp_reg;
        rp_next     = rp_reg;
        err_wr_next = err_wr_reg;
        err_rd_next = err_rd_reg;
        if (commit_fire) begin
            state_next[wp_reg] = BANK_FULL;
            wp_next            = ~wp_reg;
        end
        if (release_fire) begin
            state_next[rp_reg] = BANK_FREE;
            rp_next            = ~rp_reg;
        end
        if ((wr_en || wr_commit) && !wr_ready) begin
            err_wr_next = 1'b1;
        end
        if ((rd_en || rd_release) && !rd_ready) begin
            err_rd_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= {BANK_FREE, BANK_FREE};
            wp_reg       <= 1'b0;
            rp_reg       <= 1'b0;
            err_wr_reg   <= 1'b0;
            err_rd_reg   <= 1'b0;
            s1_valid_reg <= 1'b0;
            s1_bank_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wp_reg       <= wp_next;
            rp_reg       <= rp_next;
            err_wr_reg   <= err_wr_next;
            err_rd_reg   <= err_rd_next;
            s1_valid_reg <= rd_fire;
            if (rd_fire) begin
                s1_bank_reg <= rp_reg;
            end
        end
    end

    // The bank index travels with each read so a release right after a read
    // still returns data from the bank that was addressed.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        dpram_bank #(
            .AWIDTH   (AWIDTH),
            .DWIDTH   (DWIDTH),
            .NUM_WORDS(NUM_WORDS)
        ) u_bank (
            .clk  (clk),
            .we   (wr_fire && !reset && (wp_reg == 1'(gi))),
            .waddr(wr_addr),
            .wdata(wr_data),
            .re   (rd_fire && !reset && (rp_reg == 1'(gi))),
            .raddr(rd_addr),
            .rdata(bank_rdata[gi])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DWIDTH-1:0] out_data_reg;
        logic              out_valid_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                out_data_reg  <= '0;
                out_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= bank_rdata[s1_bank_reg];
                end
            end
        end

        assign rd_data       = out_data_reg;
        assign rd_data_valid = out_valid_reg;
    end else begin : g_no_out_reg
        // Bank read registers hold between reads; mask them to zero until the
        // first read after reset so rd_data reads as cleared.
        logic seen_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                seen_reg <= 1'b0;
            end else if (rd_fire) begin
                seen_reg <= 1'b1;
            end
        end

        assign rd_data       = seen_reg ? bank_rdata[s1_bank_reg] : '0;
        assign rd_data_valid = s1_valid_reg;
    end

endmodule

// File: tb/tb_dbram_pingpong.sv
// Self-checking bench for dbram_pingpong: a directed vector table, hand-written
// handover sequences and a randomized run against a behavioural model.
module tb_dbram_pingpong;

    localparam int AW = 4;
    localparam int NW = 16;
    localparam int DW = 16;
    localparam int OR = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_commit = 1'b0;
    logic          wr_ready;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          rd_release = 1'b0;
    logic          rd_ready;
    logic          wr_bank;
    logic          rd_bank;
    logic          err_wr;
    logic          err_rd;

    dbram_pingpong #(
        .AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW), .OUT_REG(OR)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .rd_release(rd_release),
        .rd_ready(rd_ready), .wr_bank(wr_bank), .rd_bank(rd_bank),
        .err_wr(err_wr), .err_rd(err_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: two banks with FREE/FULL flags, pointers, and a queue
    // of pending read returns stamped with the cycle they become visible.
    typedef struct {
        int           due;
        bit           known;
        logic [DW-1:0] data;
    } rdq_t;

    bit            m_full [2];
    bit            m_wp, m_rp, m_err_wr, m_err_rd;
    logic [DW-1:0] m_mem   [2][NW];
    bit            m_known [2][NW];
    rdq_t          rq [$];
    int            cyc_n = 0;
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            m_data_known;

    typedef struct {
        bit            rst, we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            wc, re;
        logic [AW-1:0] ra;
        bit            rel;
        bit            e_wr_ready, e_rd_ready, e_valid;
        logic [DW-1:0] e_data;
        bit            e_wb, e_rb;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input bit wc, input bit re,
                              input logic [AW-1:0] ra, input bit rel);
        bit wok, rok, owp, orp;
        m_valid = 1'b0;
        if (rst) begin
            m_full[0] = 1'b0; m_full[1] = 1'b0;
            m_wp = 1'b0; m_rp = 1'b0;
            m_err_wr = 1'b0; m_err_rd = 1'b0;
            rq.delete();
            m_data = '0; m_data_known = 1'b1;
        end else begin
            wok = !m_full[m_wp];
            rok = m_full[m_rp];
            owp = m_wp;
            orp = m_rp;
            if (we && wok) begin
                m_mem[owp][wa]   = wd;
                m_known[owp][wa] = 1'b1;
            end
            if ((we || wc) && !wok) m_err_wr = 1'b1;
            if ((re || rel) && !rok) m_err_rd = 1'b1;
            if (re && rok) rq.push_back('{cyc_n + OR, m_known[orp][ra], m_mem[orp][ra]});
            if (wc && wok) begin m_full[owp] = 1'b1; m_wp = ~owp; end
            if (rel && rok) begin m_full[orp] = 1'b0; m_rp = ~orp; end
            if (rq.size() > 0 && rq[0].due == cyc_n) begin
                m_valid      = 1'b1;
                m_data       = rq[0].data;
                m_data_known = rq[0].known;
                void'(rq.pop_front());
            end
        end
    endtask

    task automatic step(input bit rst, input bit we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input bit wc, input bit re,
                        input logic [AW-1:0] ra, input bit rel);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; wr_commit = wc;
        rd_en = re; rd_addr = ra; rd_release = rel;
        model_step(rst, we, wa, wd, wc, re, ra, rel);
        @(posedge clk);
        #1;
        cyc_n++;
        chk("wr_ready", wr_ready, !m_full[m_wp]);
        chk("rd_ready", rd_ready, m_full[m_rp]);
        chk("wr_bank", wr_bank, m_wp);
        chk("rd_bank", rd_bank, m_rp);
        chk("err_wr", err_wr, m_err_wr);
        chk("err_rd", err_rd, m_err_rd);
        chk("rd_data_valid", rd_data_valid, m_valid);
        if (m_data_known) chk("rd_data", rd_data, m_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, 0);
    endtask

    function automatic vec_t mk(input bit rst, input bit we, input int wa, input int wd,
                                input bit wc, input bit re, input int ra,
                                input bit ewr, input bit erd, input bit ev, input int ed,
                                input bit ewb, input bit erb);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = AW'(wa); v.wd = DW'(wd); v.wc = wc;
        v.re = re; v.ra = AW'(ra); v.rel = 1'b0;
        v.e_wr_ready = ewr; v.e_rd_ready = erd; v.e_valid = ev; v.e_data = DW'(ed);
        v.e_wb = ewb; v.e_rb = erb;
        return v;
    endfunction

    initial begin
        // Basic fill / commit / read with two-cycle read latency.
        tbl[0]  = mk(1, 0, 0, 0,    0, 0, 0, 1, 0, 0, 0,    0, 0);
        tbl[1]  = mk(0, 1, 0, 'h11, 0, 0, 0, 1, 0, 0, 0,    0, 0);
        tbl[2]  = mk(0, 1, 1, 'h12, 0, 0, 0, 1, 0, 0, 0,    0, 0);
        tbl[3]  = mk(0, 1, 2, 'h13, 0, 0, 0, 1, 0, 0, 0,    0, 0);
        tbl[4]  = mk(0, 1, 3, 'h14, 1, 0, 0, 1, 1, 0, 0,    1, 0);
        tbl[5]  = mk(0, 0, 0, 0,    0, 1, 0, 1, 1, 0, 0,    1, 0);
        tbl[6]  = mk(0, 0, 0, 0,    0, 1, 1, 1, 1, 1, 'h11, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0,    0, 1, 2, 1, 1, 1, 'h12, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0,    0, 1, 3, 1, 1, 1, 'h13, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0,    0, 0, 0, 1, 1, 1, 'h14, 1, 0);
        tbl[10] = mk(0, 0, 0, 0,    0, 0, 0, 1, 1, 0, 'h14, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wc,
                 tbl[i].re, tbl[i].ra, tbl[i].rel);
            chk($sformatf("tbl%0d.wr_ready", i), wr_ready, tbl[i].e_wr_ready);
            chk($sformatf("tbl%0d.rd_ready", i), rd_ready, tbl[i].e_rd_ready);
            chk($sformatf("tbl%0d.valid", i), rd_data_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d.data", i), rd_data, tbl[i].e_data);
            chk($sformatf("tbl%0d.wr_bank", i), wr_bank, tbl[i].e_wb);
            chk($sformatf("tbl%0d.rd_bank", i), rd_bank, tbl[i].e_rb);
        end

        // Concurrent fill of bank1 while draining bank0 every cycle.
        step(1, 0, '0, '0, 0, 0, '0, 0);
        for (int i = 0; i < NW; i++)
            step(0, 1, AW'(i), DW'('h50 + i), (i == NW - 1), 0, '0, 0);
        for (int i = 0; i < NW; i++)
            step(0, 1, AW'(i), DW'('hA0 + i), 0, 1, AW'(i), 0);
        idle(3);
        chk("stream.wr_bank", wr_bank, 1'b1);
        chk("stream.rd_bank", rd_bank, 1'b0);
        chk("stream.err", {err_wr, err_rd}, 2'b00);

        // Both banks full: writes are dropped and flagged until a release.
        step(0, 0, '0, '0, 1, 0, '0, 0);
        chk("full.wr_ready", wr_ready, 1'b0);
        step(0, 1, AW'(5), DW'('hDEAD), 0, 0, '0, 0);
        chk("full.err_wr", err_wr, 1'b1);
        step(0, 0, '0, '0, 0, 0, '0, 1);
        chk("release.wr_ready", wr_ready, 1'b1);

        // Read then release: the in-flight read returns old-bank data.
        step(0, 0, '0, '0, 0, 1, AW'(5), 0);
        step(0, 0, '0, '0, 0, 0, '0, 1);
        chk("rel.rd_bank", rd_bank, 1'b0);
        chk("rel.valid", rd_data_valid, 1'b1);
        chk("rel.old_data", rd_data, DW'('hA5));

        // Read and release with nothing committed.
        step(1, 0, '0, '0, 0, 0, '0, 0);
        step(0, 0, '0, '0, 0, 1, AW'(2), 1);
        idle(2);
        chk("empty.valid", rd_data_valid, 1'b0);
        chk("empty.err_rd", err_rd, 1'b1);
        step(1, 0, '0, '0, 0, 0, '0, 0);
        chk("empty.reset_err_rd", err_rd, 1'b0);

        // Reset in the middle of a fill and a read.
        for (int i = 0; i < 4; i++) step(0, 1, AW'(i), DW'('h30 + i), (i == 3), 0, '0, 0);
        step(0, 1, AW'(0), DW'('h77), 0, 1, AW'(1), 0);
        step(1, 1, AW'(1), DW'('h78), 0, 1, AW'(2), 0);
        chk("midrst.wr_ready", wr_ready, 1'b1);
        chk("midrst.rd_ready", rd_ready, 1'b0);
        idle(1);
        chk("midrst.no_stale_valid", rd_data_valid, 1'b0);
        chk("midrst.rd_data", rd_data, '0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(299) == 0), ($urandom_range(1) == 1), AW'($urandom),
                 DW'($urandom), ($urandom_range(15) == 0), ($urandom_range(1) == 1),
                 AW'($urandom), ($urandom_range(15) == 0));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbram_pingpong.md
DBRAM_PINGPONG -- requirements
Module: dbram_pingpong

Interface
REQ-001 SHALL have parameter AWIDTH, default 11, meaning bank address width.
REQ-002 SHALL have parameter NUM_WORDS, default 2048, meaning words per bank (≤ 2^AWIDTH).
REQ-003 SHALL have parameter DWIDTH, default 40, meaning data width.
REQ-004 SHALL have parameter OUT_REG, default 1, meaning extra read-output register stage (0 or 1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1, which writes wr_data to the fill bank at wr_addr.
REQ-008 SHALL have ports wr_addr (input, AWIDTH) and wr_data (input, DWIDTH).
REQ-009 SHALL have port wr_commit, input, 1, meaning the producer has finished the fill bank.
REQ-010 SHALL have port wr_ready, output, 1, meaning the fill bank is FREE.
REQ-011 SHALL have ports rd_en (input, 1) and rd_addr (input, AWIDTH), which read the drain bank.
REQ-012 SHALL have ports rd_data (output, DWIDTH) and rd_data_valid (output, 1).
REQ-013 SHALL have port rd_release, input, 1, meaning the consumer has finished the drain bank.
REQ-014 SHALL have port rd_ready, output, 1, meaning the drain bank is FULL.
REQ-015 SHALL have ports wr_bank and rd_bank, output, 1 each, giving the current fill and drain bank indices.
REQ-016 SHALL have ports err_wr and err_rd, output, 1 each, as sticky protocol-error flags.

Function
REQ-017 SHALL hold two banks, each with state FREE or FULL, plus fill pointer wp and drain pointer rp.
REQ-018 SHALL drive wr_ready = (state[wp]==FREE) and rd_ready = (state[rp]==FULL), combinationally from registers.
REQ-019 SHALL, on wr_en && wr_ready, write mem[wp][wr_addr] <= wr_data; on wr_en && !wr_ready, drop the write and set err_wr.
REQ-020 SHALL, on wr_commit && wr_ready, set state[wp] <= FULL and toggle wp next cycle; on wr_commit && !wr_ready, ignore it and set err_wr.
REQ-021 SHALL, when wr_en and wr_commit occur in the same cycle, land the write in the bank being committed.
REQ-022 SHALL, on rd_en && rd_ready, read mem[rp][rd_addr], with rd_data_valid high for exactly one cycle, 1+OUT_REG cycles later.
REQ-023 SHALL ignore rd_en && !rd_ready (no valid pulse) and set err_rd.
REQ-024 SHALL, on rd_release && rd_ready, set state[rp] <= FREE and toggle rp; on rd_release && !rd_ready, ignore it and set err_rd.
REQ-025 SHALL apply a commit and a release in the same cycle independently (legal only when wp != rp).
REQ-026 SHALL pipeline the bank index with each read, so reads issued before a release still return old-bank data.
REQ-027 SHALL hold rd_data at its last value when no read completes.
REQ-028 SHALL treat addresses ≥ NUM_WORDS as undefined data, with no error flag.
REQ-029 SHALL sustain full throughput: one write and one read per cycle, since they target different banks.

Reset
REQ-030 SHALL on reset set both states to FREE, wp=0, rp=0, err_wr=0, err_rd=0, rd_data=0, rd_data_valid=0, and flush in-flight reads.
REQ-031 SHALL give reset priority over all inputs in the same cycle.
REQ-032 SHALL NOT clear memory contents on reset.

Structure
REQ-033 SHALL place bank-state encodings (FREE=0, FULL=1) and default parameter constants in a shared package/header.
REQ-034 SHALL instantiate sub-module dpram_bank twice (simple dual-port: one write port, one registered read port, AWIDTH/DWIDTH parameters).
REQ-035 SHALL select the hard_mem dual_port_ram primitive inside dpram_bank when hard_mem is defined.

Verification
REQ-036 Reset, then write addr 0..3 = 0x11..0x14, commit; read 0..3 -> rd_data 0x11..0x14, valid at issue+1+OUT_REG, rd_bank=0.
REQ-037 Fill bank0, commit, fill bank1 with 0xA0.. while reading bank0 every cycle -> both streams correct, no errors, wr_bank=1, rd_bank=0.
REQ-038 Commit both banks without release -> wr_ready=0; extra wr_en -> dropped, err_wr=1; release -> wr_ready=1 next cycle.
REQ-039 Issue rd_en at addr 5 then rd_release next cycle -> returned data from old bank; rd_bank toggles.
REQ-040 rd_en and rd_release with no committed bank -> no valid, err_rd=1; reset -> err_rd=0.
REQ-041 Assert reset mid-fill and mid-read -> wr_ready=1, rd_ready=0, no stale rd_data_valid after reset.
